muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic        sign_a, sign_b, dz_q;
  logic [4:0]  cnt;
  logic [31:0] opnd;
  logic [63:0] acc;

  logic        accept, fix_fire, write_hl;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] acc_step, prod;
  logic [31:0] quot, rem, res_hi, res_lo;

  // Signed ops work on magnitudes; op[0]=0 selects the signed variants.
  assign mag_a  = (~op[0] & a[31]) ? -a : a;
  assign mag_b  = (~op[0] & b[31]) ? -b : b;
  assign accept = (state == IDLE) && start && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (op[1] && (b == 32'd0)) state_nxt = FIX;
`ifdef MULDIV_FAST_MUL_EN
        else if (!op[1])           state_nxt = FIX;
`endif
        else                       state_nxt = CALC;
      end
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    busy     = (state != IDLE);
    fix_fire = (state == FIX) && !flush;
    write_hl = fix_fire && !dz_q;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[31:0] - opnd;
    if (op_q[1])
      acc_step = div_ge ? {div_diff, acc[30:0], 1'b1} : {div_shift[31:0], acc[30:0], 1'b0};
    else
      acc_step = {mul_sum, acc[31:1]};
  end

  always_comb begin
    prod   = (~op_q[0] & (sign_a ^ sign_b)) ? -acc : acc;
    quot   = (~op_q[0] & (sign_a ^ sign_b)) ? -acc[31:0] : acc[31:0];
    rem    = (~op_q[0] & sign_a) ? -acc[63:32] : acc[63:32];
    res_hi = op_q[1] ? rem  : prod[63:32];
    res_lo = op_q[1] ? quot : prod[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 2'b00;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dz_q     <= 1'b0;
      cnt      <= 5'd0;
      opnd     <= 32'd0;
      acc      <= 64'd0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      done     <= fix_fire;
      div_zero <= fix_fire & dz_q;
      if (accept) begin
        op_q   <= op;
        sign_a <= a[31];
        sign_b <= b[31];
        dz_q   <= op[1] & (b == 32'd0);
        cnt    <= 5'd0;
        opnd   <= op[1] ? mag_b : mag_a;
        acc    <= op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
`ifdef MULDIV_FAST_MUL_EN
        if (!op[1]) acc <= {32'd0, mag_a} * {32'd0, mag_b};
`endif
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + 5'd1;
      end
      // A completing operation overrides same-edge MTHI/MTLO writes.
      if (write_hl)   hi <= res_hi;
      else if (hi_we) hi <= hi_wdata;
      if (write_hl)   lo <= res_lo;
      else if (lo_we) lo <= lo_wdata;
    end
  end

endmodule
